// File: rtl/hud_pkg.sv
// Shared types, constants and ASCII packing helpers for the HUD digit sequencer.
package hud_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SHIFT,
        STORE,
        DONE
    } hud_seq_state_t;

    localparam logic [7:0] ASCII_ZERO = 8'h30;
    localparam int         SCORE_MAX  = 9999;
    localparam int         SMALL_MAX  = 99;
    localparam int         NUM_FIELDS = 3;
    localparam int         BCD_W      = 16;

    // One BCD nibble to its ASCII character code.
    function automatic logic [7:0] nibbleToAscii(input logic [3:0] nib);
        return ASCII_ZERO + {4'h0, nib};
    endfunction

    // Four BCD nibbles to {d3,d2,d1,d0} ASCII, d3 = thousands.
    function automatic logic [31:0] bcd4ToAscii(input logic [15:0] bcd);
        return {nibbleToAscii(bcd[15:12]), nibbleToAscii(bcd[11:8]),
                nibbleToAscii(bcd[7:4]), nibbleToAscii(bcd[3:0])};
    endfunction

    // Two BCD nibbles to {d1,d0} ASCII.
    function automatic logic [15:0] bcd2ToAscii(input logic [7:0] bcd);
        return {nibbleToAscii(bcd[7:4]), nibbleToAscii(bcd[3:0])};
    endfunction

endpackage

// File: rtl/bcd_add3_step.sv
// Double-dabble correction step: every BCD nibble >= 5 gets 3 added so the
// following left shift carries correctly into the next decimal digit.
module bcd_add3_step
    import hud_pkg::*;
(
    input  logic [BCD_W-1:0] bcdIn,
    output logic [BCD_W-1:0] bcdOut
);

    // Per-nibble conditional add-3.
    always_comb begin
        bcdOut = bcdIn;
        for (int i = 0; i < BCD_W / 4; i++) begin
            if (bcdIn[i*4 +: 4] >= 4'd5) begin
                bcdOut[i*4 +: 4] = bcdIn[i*4 +: 4] + 4'd3;
            end
        end
    end

endmodule

// File: rtl/hud_digit_sequencer.sv
// Per-frame HUD digit sequencer. Snapshots score/lives/level on frame_start,
// converts them one after another through a single shared double-dabble
// engine, and publishes all ASCII digits together on entry to DONE.
//
// Handshake: frame_start is a one-cycle request with no ready/back-pressure;
// it is accepted only while the FSM is in IDLE and dropped otherwise (never
// queued). done is a one-cycle strobe, and the digit outputs carry the new
// frame's values in that same cycle and hold them until the next done or reset.
module hud_digit_sequencer
    import hud_pkg::*;
#(
    parameter int IN_W = 16
) (
    input  logic            Clk,
    input  logic            Reset_n,
    input  logic            frame_start,
    input  logic [IN_W-1:0] ScoreInt,
    input  logic [IN_W-1:0] LivesInt,
    input  logic [IN_W-1:0] LevelInt,
    output logic [31:0]     score_ascii,
    output logic [15:0]     lives_ascii,
    output logic [15:0]     level_ascii,
    output logic            busy,
    output logic            done,
    output hud_seq_state_t  seqState
);

    localparam int CNT_W = (IN_W > 1) ? $clog2(IN_W) : 1;

    localparam logic [IN_W-1:0]  SCORE_LIMIT = IN_W'(SCORE_MAX);
    localparam logic [IN_W-1:0]  SMALL_LIMIT = IN_W'(SMALL_MAX);
    localparam logic [1:0]       LAST_IDX    = 2'(NUM_FIELDS - 1);
    localparam logic [CNT_W-1:0] SHIFT_LAST  = CNT_W'(IN_W - 1);

    hud_seq_state_t state;
    hud_seq_state_t nextState;

    logic [IN_W-1:0]  snapScore;
    logic [IN_W-1:0]  snapLives;
    logic [IN_W-1:0]  snapLevel;
    logic [1:0]       idx;

    logic [IN_W-1:0]  selVal;
    logic [IN_W-1:0]  satVal;

    logic [IN_W-1:0]  binReg;
    logic [BCD_W-1:0] bcdReg;
    logic [BCD_W-1:0] bcdAdj;
    logic [CNT_W-1:0] shiftCnt;

    logic [15:0]      shadowScore;
    logic [7:0]       shadowLives;
    logic [7:0]       shadowLevel;

    // State register.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next-state logic: three LOAD/SHIFT/STORE passes, then a single DONE cycle.
    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (frame_start) nextState = LOAD;
            LOAD:    nextState = SHIFT;
            SHIFT:   if (shiftCnt == '0) nextState = STORE;
            STORE:   nextState = (idx < LAST_IDX) ? LOAD : DONE;
            DONE:    nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // Status decode straight from the state register, so both are glitch-free.
    always_comb begin
        busy     = (state == LOAD) || (state == SHIFT) || (state == STORE);
        done     = (state == DONE);
        seqState = state;
    end

    // Pick the snapshot for the current field and clamp it to what its digits can show.
    always_comb begin
        selVal = snapScore;
        satVal = snapScore;
        case (idx)
            2'd0: begin
                selVal = snapScore;
                satVal = (selVal > SCORE_LIMIT) ? SCORE_LIMIT : selVal;
            end
            2'd1: begin
                selVal = snapLives;
                satVal = (selVal > SMALL_LIMIT) ? SMALL_LIMIT : selVal;
            end
            default: begin
                selVal = snapLevel;
                satVal = (selVal > SMALL_LIMIT) ? SMALL_LIMIT : selVal;
            end
        endcase
    end

    bcd_add3_step u_add3 (
        .bcdIn  (bcdReg),
        .bcdOut (bcdAdj)
    );

    // Snapshot capture and field index.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            snapScore <= '0;
            snapLives <= '0;
            snapLevel <= '0;
            idx       <= '0;
        end else if (state == IDLE && frame_start) begin
            snapScore <= ScoreInt;
            snapLives <= LivesInt;
            snapLevel <= LevelInt;
            idx       <= '0;
        end else if (state == STORE) begin
            idx <= idx + 2'd1;
        end
    end

    // Shared conversion engine: load, then IN_W rounds of add-3 followed by a left shift.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            binReg   <= '0;
            bcdReg   <= '0;
            shiftCnt <= '0;
        end else if (state == LOAD) begin
            binReg   <= satVal;
            bcdReg   <= '0;
            shiftCnt <= SHIFT_LAST;
        end else if (state == SHIFT) begin
            {bcdReg, binReg} <= {bcdAdj, binReg} << 1;
            if (shiftCnt != '0) begin
                shiftCnt <= shiftCnt - 1'b1;
            end
        end
    end

    // Shadow the finished field; the last field's STORE also publishes every output
    // at once, so the renderer never sees a mix of old and new digits.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            shadowScore <= '0;
            shadowLives <= '0;
            shadowLevel <= '0;
            score_ascii <= {4{ASCII_ZERO}};
            lives_ascii <= {2{ASCII_ZERO}};
            level_ascii <= {2{ASCII_ZERO}};
        end else if (state == STORE) begin
            case (idx)
                2'd0:    shadowScore <= bcdReg;
                2'd1:    shadowLives <= bcdReg[7:0];
                default: shadowLevel <= bcdReg[7:0];
            endcase
            if (nextState == DONE) begin
                score_ascii <= bcd4ToAscii(shadowScore);
                lives_ascii <= bcd2ToAscii(shadowLives);
                level_ascii <= bcd2ToAscii(bcdReg[7:0]);
            end
        end
    end

endmodule

// File: tb/tb_hud_digit_sequencer.sv
// Self-checking bench for hud_digit_sequencer: table-driven frames plus
// hand-written sequences for ignored requests, back-to-back frames and mid-frame reset.
module tb_hud_digit_sequencer;
    import hud_pkg::*;

    localparam int W = 64;

    logic           Clk;
    logic           Reset_n;
    logic           frame_start;
    logic [15:0]    ScoreInt;
    logic [15:0]    LivesInt;
    logic [15:0]    LevelInt;
    logic [31:0]    score_ascii;
    logic [15:0]    lives_ascii;
    logic [15:0]    level_ascii;
    logic           busy;
    logic           done;
    hud_seq_state_t seqState;

    logic [W-1:0] exp_q[$];
    int checks;
    int errors;
    int doneCount;
    int framesRun;

    typedef struct {
        int          score;
        int          lives;
        int          level;
        logic [31:0] expScore;
        logic [15:0] expLives;
        logic [15:0] expLevel;
    } vec_t;

    vec_t vecs[6];

    hud_digit_sequencer #(.IN_W(16)) dut (
        .Clk         (Clk),
        .Reset_n     (Reset_n),
        .frame_start (frame_start),
        .ScoreInt    (ScoreInt),
        .LivesInt    (LivesInt),
        .LevelInt    (LevelInt),
        .score_ascii (score_ascii),
        .lives_ascii (lives_ascii),
        .level_ascii (level_ascii),
        .busy        (busy),
        .done        (done),
        .seqState    (seqState)
    );

    // Clock.
    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Hard stop in case something wedges outside the bounded waits.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    function automatic logic [7:0] asc(input int d);
        return 8'(48 + d);
    endfunction

    // Reference model: clamp, then plain decimal digits by divide/modulo.
    function automatic logic [W-1:0] model(input int s, input int l, input int v);
        int sc;
        int li;
        int lv;
        sc = (s > 9999) ? 9999 : s;
        li = (l > 99) ? 99 : l;
        lv = (v > 99) ? 99 : v;
        return {asc(sc / 1000), asc((sc / 100) % 10), asc((sc / 10) % 10), asc(sc % 10),
                asc(li / 10), asc(li % 10), asc(lv / 10), asc(lv % 10)};
    endfunction

    // Scoreboard: every done pops one expected frame and compares all digits.
    always @(negedge Clk) begin
        logic [W-1:0] expv;
        if (Reset_n && done) begin
            doneCount++;
            check("busy_during_done", W'(busy), W'(0));
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done with %0d pending frames, expected none", exp_q.size());
            end else begin
                expv = exp_q.pop_front();
                check("digits", {score_ascii, lives_ascii, level_ascii}, expv);
            end
        end
    end

    // Drive one accepted frame_start and follow it to the return to IDLE.
    // glitchCycle > 0 re-pulses frame_start (with ScoreInt = 42) in that cycle;
    // pulseInDone raises frame_start during the DONE cycle.
    task automatic runFrame(input int s, input int l, input int v, input logic [W-1:0] expv,
                            input int glitchCycle, input bit pulseInDone);
        int cyc;
        @(negedge Clk);
        ScoreInt    = 16'(s);
        LivesInt    = 16'(l);
        LevelInt    = 16'(v);
        frame_start = 1'b1;
        @(posedge Clk);
        exp_q.push_back(expv);
        framesRun++;
        #1;
        frame_start = 1'b0;
        cyc = 1;
        check("busy_cycle1", W'(busy), W'(1));
        // Inputs moving after the snapshot must not leak into this frame.
        ScoreInt = 16'($urandom_range(0, 65535));
        LivesInt = 16'($urandom_range(0, 65535));
        LevelInt = 16'($urandom_range(0, 65535));
        while (!done && cyc < 200) begin
            if (cyc == glitchCycle) begin
                frame_start = 1'b1;
                ScoreInt    = 16'd42;
            end
            @(posedge Clk);
            #1;
            frame_start = 1'b0;
            cyc++;
        end
        check("done_cycle", W'(cyc), W'(55));
        if (pulseInDone) frame_start = 1'b1;
        @(posedge Clk);
        #1;
        frame_start = 1'b0;
        check("idle_after_done", W'(seqState), W'(IDLE));
        check("done_one_cycle", W'(done), W'(0));
        check("busy_after_done", W'(busy), W'(0));
    endtask

    initial begin
        int s;
        int l;
        int v;
        checks      = 0;
        errors      = 0;
        doneCount   = 0;
        framesRun   = 0;
        Reset_n     = 1'b0;
        frame_start = 1'b0;
        ScoreInt    = 16'd0;
        LivesInt    = 16'd0;
        LevelInt    = 16'd0;

        vecs[0] = '{1234, 3, 12, 32'h31323334, 16'h3033, 16'h3132};
        vecs[1] = '{10000, 100, 65535, 32'h39393939, 16'h3939, 16'h3939};
        vecs[2] = '{9999, 99, 99, 32'h39393939, 16'h3939, 16'h3939};
        vecs[3] = '{0, 0, 0, 32'h30303030, 16'h3030, 16'h3030};
        vecs[4] = '{5, 50, 9, 32'h30303035, 16'h3530, 16'h3039};
        vecs[5] = '{8765, 10, 98, 32'h38373635, 16'h3130, 16'h3938};

        // Reset held for two cycles.
        repeat (2) @(posedge Clk);
        #1;
        check("reset_score", W'(score_ascii), W'(32'h30303030));
        check("reset_lives", W'(lives_ascii), W'(16'h3030));
        check("reset_level", W'(level_ascii), W'(16'h3030));
        check("reset_busy", W'(busy), W'(0));
        check("reset_done", W'(done), W'(0));
        check("reset_state", W'(seqState), W'(IDLE));
        Reset_n = 1'b1;
        repeat (2) @(posedge Clk);

        // Table-driven frames.
        for (int i = 0; i < 6; i++) begin
            runFrame(vecs[i].score, vecs[i].lives, vecs[i].level,
                     {vecs[i].expScore, vecs[i].expLives, vecs[i].expLevel}, 0, 1'b0);
        end

        // Random frames against the divide/modulo model.
        for (int i = 0; i < 4; i++) begin
            s = $urandom_range(0, 20000);
            l = $urandom_range(0, 150);
            v = $urandom_range(0, 150);
            runFrame(s, l, v, model(s, l, v), 0, 1'b0);
        end

        // Request at cycle 20 with a new score: ignored, only the snapshot is published.
        runFrame(1234, 3, 12, {32'h31323334, 16'h3033, 16'h3132}, 20, 1'b0);
        repeat (60) @(posedge Clk);

        // Request during DONE is dropped; then a request right after DONE is accepted.
        runFrame(4321, 21, 34, {32'h34333231, 16'h3231, 16'h3334}, 0, 1'b1);
        runFrame(777, 7, 3, {32'h30373737, 16'h3037, 16'h3033}, 0, 1'b0);
        runFrame(0, 7, 3, {32'h30303030, 16'h3037, 16'h3033}, 0, 1'b0);

        // Reset while lives is shifting: outputs return to "0" and no done follows.
        @(negedge Clk);
        ScoreInt    = 16'd5678;
        LivesInt    = 16'd42;
        LevelInt    = 16'd7;
        frame_start = 1'b1;
        @(posedge Clk);
        #1;
        frame_start = 1'b0;
        repeat (24) @(posedge Clk);
        #1;
        check("mid_reset_in_shift", W'(seqState), W'(SHIFT));
        Reset_n = 1'b0;
        @(posedge Clk);
        #1;
        Reset_n = 1'b1;
        check("mid_reset_score", W'(score_ascii), W'(32'h30303030));
        check("mid_reset_lives", W'(lives_ascii), W'(16'h3030));
        check("mid_reset_level", W'(level_ascii), W'(16'h3030));
        check("mid_reset_busy", W'(busy), W'(0));
        check("mid_reset_state", W'(seqState), W'(IDLE));
        repeat (70) @(posedge Clk);
        runFrame(5678, 42, 7, {32'h35363738, 16'h3432, 16'h3037}, 0, 1'b0);

        repeat (5) @(posedge Clk);
        check("queue_empty", W'(exp_q.size()), W'(0));
        check("done_count", W'(doneCount), W'(framesRun));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
